// File: rtl/lcd_value_fmt_if.sv
// Bus between the value formatter and its requester / LCD driver side.
// Carries the start request and value in, the busy flag from the LCD driver,
// and the character-buffer write port, repaint pulse and ready flag out.
interface lcd_value_fmt_if;
   logic [23:0] value;    // number to display, sampled on an accepted start
   logic        start;    // format-and-display request (pulse or level)
   logic        busy;     // LCD driver busy flag (repaint in progress)
   logic [7:0]  dat;      // ASCII character for the character buffer
   logic [4:0]  addr;     // character-buffer address for dat
   logic        we;       // character-buffer write enable
   logic        repaint;  // one-cycle redraw request to the LCD driver
   logic        ready;    // high only while the formatter is idle

   // Formatter side
   modport slave (
      input  value, start, busy,
      output dat, addr, we, repaint, ready
   );

   // Requester / LCD driver side
   modport master (
      output value, start, busy,
      input  dat, addr, we, repaint, ready
   );
endinterface

// File: rtl/lcd_value_fmt.sv
// Formats a 24-bit value as a signed 7-digit decimal row and writes it into an LCD character buffer.
// Latency: writes in cycles 25..40 after the start edge, repaint in cycle 42, ready again in cycle 43 (busy low).
// Backpressure: start is only taken while ready; busy stalls only the repaint request, never the writes.
// Ports: CLK12 clock, reset_n async active-low reset, bus (slave modport): value/start/busy in,
//        dat/addr/we/repaint/ready out.
module lcd_value_fmt #(
   parameter int ROW       = 0,     // 0: addresses 0-15, otherwise 16-31
   parameter bit SIGNED_IN = 1'b1   // 1: value is two's complement
) (
   input  logic           CLK12,
   input  logic           reset_n,
   lcd_value_fmt_if.slave bus
);

   localparam logic [4:0] ROW_BASE = (ROW != 0) ? 5'd16 : 5'd0;

   typedef enum logic [2:0] {
      IDLE,
      CONV,
      WRITE,
      WAIT_BUSY,
      REPAINT
   } state_t;

   state_t      state, state_nxt;

   logic [23:0] mag;       // magnitude being shifted out during conversion
   logic [27:0] bcd;       // seven BCD digits, most significant in [27:24]
   logic        neg;       // sign of the captured value
   logic [4:0]  cnt;       // double-dabble iteration counter, 0..23
   logic [4:0]  widx;      // character index; 16 means all writes issued

   logic [7:0]  dat_q;
   logic [4:0]  addr_q;
   logic        we_q;
   logic        repaint_q;

   logic        neg_in;
   logic [23:0] mag_in;
   logic [27:0] bcd_adj;
   logic [51:0] dd_sh;
   logic [6:0]  lead_nz;
   logic        nz;
   logic [2:0]  dig_k;
   logic [3:0]  digit;
   logic [7:0]  char_nxt;

   // Magnitude of the incoming value; negating 0x800000 gives 0x800000,
   // which read as unsigned is the correct magnitude 8388608.
   always_comb begin
      neg_in = SIGNED_IN && bus.value[23];
      mag_in = neg_in ? (~bus.value + 24'd1) : bus.value;
   end

   // One double-dabble step: correct every digit >= 5, then shift {bcd,mag}.
   always_comb begin
      bcd_adj = bcd;
      for (int j = 0; j < 7; j++) begin
         if (bcd[4*j +: 4] >= 4'd5)
            bcd_adj[4*j +: 4] = bcd[4*j +: 4] + 4'd3;
      end
      dd_sh = {bcd_adj[26:0], mag, 1'b0};
   end

   // Character for the current write index. lead_nz[k] is set when digit k
   // or any more significant digit is non-zero, so a clear bit marks a
   // leading zero that is shown as a blank (the units digit never blanks).
   always_comb begin
      nz      = 1'b0;
      lead_nz = '0;
      for (int j = 6; j >= 0; j--) begin
         nz         = nz | (bcd[4*j +: 4] != 4'd0);
         lead_nz[j] = nz;
      end
      dig_k    = 3'(5'd7 - widx);
      digit    = bcd[{dig_k, 2'b00} +: 4];
      char_nxt = 8'h20;
      if (widx == 5'd0)
         char_nxt = neg ? 8'h2D : 8'h2B;
      else if ((widx <= 5'd7) && ((dig_k == 3'd0) || lead_nz[dig_k]))
         char_nxt = {4'h3, digit};
   end

   // State register
   always_ff @(posedge CLK12 or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic. WRITE runs one extra cycle (widx == 16) so that the
   // sixteenth registered write has been taken by the buffer before waiting.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (bus.start)       state_nxt = CONV;
         CONV:      if (cnt == 5'd23)    state_nxt = WRITE;
         WRITE:     if (widx == 5'd16)   state_nxt = WAIT_BUSY;
         WAIT_BUSY: if (!bus.busy)       state_nxt = REPAINT;
         REPAINT:                        state_nxt = IDLE;
         default:                        state_nxt = IDLE;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge CLK12 or negedge reset_n) begin
      if (!reset_n) begin
         mag       <= '0;
         bcd       <= '0;
         neg       <= 1'b0;
         cnt       <= '0;
         widx      <= '0;
         dat_q     <= 8'h20;
         addr_q    <= '0;
         we_q      <= 1'b0;
         repaint_q <= 1'b0;
      end else begin
         we_q      <= 1'b0;
         repaint_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  mag  <= mag_in;
                  neg  <= neg_in;
                  bcd  <= '0;
                  cnt  <= '0;
                  widx <= '0;
               end
            end
            CONV: begin
               {bcd, mag} <= dd_sh;
               cnt        <= cnt + 5'd1;
            end
            WRITE: begin
               if (widx != 5'd16) begin
                  we_q   <= 1'b1;
                  dat_q  <= char_nxt;
                  addr_q <= ROW_BASE + widx;
                  widx   <= widx + 5'd1;
               end
            end
            WAIT_BUSY: begin
               if (!bus.busy)
                  repaint_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.dat     = dat_q;
   assign bus.addr    = addr_q;
   assign bus.we      = we_q;
   assign bus.repaint = repaint_q;
   assign bus.ready   = (state == IDLE);

endmodule

// File: tb/tb_lcd_value_fmt.sv
// Self-checking bench for lcd_value_fmt: two instances (row 0 signed, row 1 unsigned),
// expected character writes queued per instance at stimulus time and popped by write monitors,
// plus cycle-accurate latency, busy-hold, start-ignore and reset-abort checks.
module tb_lcd_value_fmt;

   logic CLK12 = 1'b0;
   logic reset_n;

   always #5 CLK12 = ~CLK12;

   lcd_value_fmt_if if0 ();
   lcd_value_fmt_if if1 ();

   lcd_value_fmt #(.ROW(0), .SIGNED_IN(1'b1)) u0 (.CLK12(CLK12), .reset_n(reset_n), .bus(if0));
   lcd_value_fmt #(.ROW(1), .SIGNED_IN(1'b0)) u1 (.CLK12(CLK12), .reset_n(reset_n), .bus(if1));

   int n_chk  = 0;
   int n_fail = 0;

   logic [12:0] q0[$];
   logic [12:0] q1[$];

   bit          sel = 1'b0;
   logic        o_we, o_rp, o_rdy;
   logic [7:0]  o_dat;
   logic [4:0]  o_addr;

   always_comb begin
      o_we   = sel ? if1.we      : if0.we;
      o_rp   = sel ? if1.repaint : if0.repaint;
      o_rdy  = sel ? if1.ready   : if0.ready;
      o_dat  = sel ? if1.dat     : if0.dat;
      o_addr = sel ? if1.addr    : if0.addr;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference row built with plain integer decimal arithmetic.
   task automatic push_row(input bit s, input logic [23:0] v);
      int   row, mag, p;
      bit   neg;
      logic [7:0] ch;
      row = s ? 1 : 0;
      neg = !s && v[23];
      mag = int'({8'h00, v});
      if (neg) mag = 16777216 - mag;
      for (int i = 0; i < 16; i++) begin
         if (i == 0)
            ch = neg ? 8'h2D : 8'h2B;
         else if (i <= 7) begin
            p = 1;
            repeat (7 - i) p = p * 10;
            if ((i != 7) && (mag < p)) ch = 8'h20;
            else ch = 8'(8'h30 + ((mag / p) % 10));
         end else
            ch = 8'h20;
         if (s) q1.push_back({5'(row * 16 + i), ch});
         else   q0.push_back({5'(row * 16 + i), ch});
      end
   endtask

   always @(negedge CLK12) begin : mon0
      logic [12:0] e;
      if (if0.we === 1'b1) begin
         if (q0.size() == 0) chk("u0_unexpected_we", 32'(if0.we), 32'd0);
         else begin
            e = q0.pop_front();
            chk("u0_wr_addr", 32'(if0.addr), 32'(e[12:8]));
            chk("u0_wr_dat",  32'(if0.dat),  32'(e[7:0]));
         end
      end
   end

   always @(negedge CLK12) begin : mon1
      logic [12:0] e;
      if (if1.we === 1'b1) begin
         if (q1.size() == 0) chk("u1_unexpected_we", 32'(if1.we), 32'd0);
         else begin
            e = q1.pop_front();
            chk("u1_wr_addr", 32'(if1.addr), 32'(e[12:8]));
            chk("u1_wr_dat",  32'(if1.dat),  32'(e[7:0]));
         end
      end
   end

   task automatic set_in(input bit s, input logic st, input logic [23:0] v, input logic b);
      if (s) begin if1.start = st; if1.value = v; if1.busy = b; end
      else   begin if0.start = st; if0.value = v; if0.busy = b; end
   endtask

   // One operation on instance s. busy_hold > 0 keeps busy high until cycle
   // 41+busy_hold and pulses start mid-operation; abort_at > 0 resets the
   // design right after that many writes were seen.
   task automatic run_op(input bit s, input logic [23:0] v, input int busy_hold, input int abort_at);
      int first_we, last_we, n_we, rp_at, n_rp, rdy_at, drop_at, exp_rp;
      logic b;
      sel = s;
      push_row(s, v);
      b = (busy_hold > 0);
      chk("ready_before_start", 32'(o_rdy), 32'd1);
      set_in(s, 1'b1, v, 1'b0);
      @(posedge CLK12);                 // start edge = cycle 0
      @(negedge CLK12);
      set_in(s, 1'b0, ~v, b);           // value change after capture must not matter
      first_we = -1; last_we = -1; n_we = 0; rp_at = -1; n_rp = 0; rdy_at = -1;
      drop_at  = (busy_hold > 0) ? 41 + busy_hold : -1;
      for (int e = 1; e <= 300; e++) begin
         @(negedge CLK12);
         if (o_we === 1'b1) begin
            n_we++;
            if (first_we < 0) first_we = e;
            last_we = e;
         end
         if (o_rp === 1'b1) begin
            n_rp++;
            if (rp_at < 0) rp_at = e;
         end
         if ((o_rdy === 1'b1) && (rdy_at < 0)) rdy_at = e;
         if ((abort_at > 0) && (n_we == abort_at)) begin
            #2 reset_n = 1'b0;
            #1;
            chk("abort_we",      32'(o_we),   32'd0);
            chk("abort_repaint", 32'(o_rp),   32'd0);
            chk("abort_ready",   32'(o_rdy),  32'd1);
            chk("abort_dat",     32'(o_dat),  32'h20);
            chk("abort_addr",    32'(o_addr), 32'd0);
            if (s) q1.delete(); else q0.delete();
            set_in(s, 1'b0, v, 1'b0);
            @(negedge CLK12);
            chk("abort_no_we_in_reset", 32'(o_we), 32'd0);
            reset_n = 1'b1;
            return;
         end
         if (busy_hold > 0) begin
            if (e == drop_at) b = 1'b0;
            set_in(s, (e == 10 || e == 30 || e == 60), ~v, b);
         end
         if ((rdy_at > 0) && (e > rdy_at + 3)) break;
      end
      set_in(s, 1'b0, v, 1'b0);
      exp_rp = (busy_hold > 0) ? drop_at + 1 : 42;
      chk("first_we_cycle", 32'(first_we), 32'd25);
      chk("last_we_cycle",  32'(last_we),  32'd40);
      chk("we_count",       32'(n_we),     32'd16);
      chk("repaint_cycle",  32'(rp_at),    32'(exp_rp));
      chk("repaint_count",  32'(n_rp),     32'd1);
      chk("ready_cycle",    32'(rdy_at),   32'(exp_rp + 1));
      chk("queue_drained",  32'(s ? q1.size() : q0.size()), 32'd0);
      chk("hold_addr",      32'(o_addr),   32'(s ? 31 : 15));
      chk("hold_dat",       32'(o_dat),    32'h20);
   endtask

   initial begin
      reset_n = 1'b0;
      set_in(1'b0, 1'b0, 24'd0, 1'b0);
      set_in(1'b1, 1'b0, 24'd0, 1'b0);
      #12;
      chk("rst_u0_we",      32'(if0.we),      32'd0);
      chk("rst_u0_repaint", 32'(if0.repaint), 32'd0);
      chk("rst_u0_ready",   32'(if0.ready),   32'd1);
      chk("rst_u0_dat",     32'(if0.dat),     32'h20);
      chk("rst_u0_addr",    32'(if0.addr),    32'd0);
      chk("rst_u1_we",      32'(if1.we),      32'd0);
      chk("rst_u1_ready",   32'(if1.ready),   32'd1);
      chk("rst_u1_dat",     32'(if1.dat),     32'h20);
      @(negedge CLK12);
      reset_n = 1'b1;
      @(negedge CLK12);

      run_op(1'b0, 24'd12345,   0, 0);
      run_op(1'b0, 24'h800000,  0, 0);   // -8388608
      run_op(1'b0, 24'd0,       0, 0);
      run_op(1'b0, 24'hFFFFFF,  0, 0);   // -1
      run_op(1'b1, 24'd9999999, 0, 0);
      run_op(1'b1, 24'd4242,  100, 0);   // row 1, busy held, stray starts
      run_op(1'b0, 24'd777,     0, 5);   // reset at the 5th write
      run_op(1'b0, 24'd31415,   0, 0);   // start on first edge after reset release

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
